// File: rtl/glm_seq_pkg.sv
// Shared types and register-map constants for the GLM update sequencer.
package glm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    FINISH
  } t_seqstate;

  localparam int REG_MODEL_IDX    = 3;
  localparam int REG_FLAGS_IDX    = 4;
  localparam int FLAG_FORWARD_BIT = 0;
  localparam int NUM_REGS         = 5;
  localparam int LINE_W           = 16;

  function automatic logic [LINE_W-1:0] min_lines(input logic [LINE_W-1:0] a,
                                                  input logic [LINE_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/glm_seq_partition_iter.sv
// Walks (sample, line) positions of a minibatch command in partition-sized steps
// and reports the current partition length and last-op flags.
module glm_seq_partition_iter
  import glm_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [LINE_W-1:0] model_length,
  input  logic [LINE_W-1:0] part_lines,
  output logic [LINE_W-1:0] line_idx,
  output logic [LINE_W-1:0] len,
  output logic              last_sample,
  output logic              last_op
);

  logic [CNT_W-1:0]  sample_idx;
  logic [LINE_W-1:0] line_nxt;
  logic              line_wrap;

  // len never exceeds the remaining lines, so line_nxt cannot overflow
  assign len         = min_lines(part_lines, model_length - line_idx);
  assign line_nxt    = line_idx + len;
  assign line_wrap   = (line_nxt == model_length);
  assign last_sample = (sample_idx == num_samples - CNT_W'(1));
  assign last_op     = line_wrap && last_sample;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_idx   <= '0;
      sample_idx <= '0;
    end else if (clear) begin
      line_idx   <= '0;
      sample_idx <= '0;
    end else if (advance) begin
      if (line_wrap) begin
        line_idx   <= '0;
        sample_idx <= sample_idx + CNT_W'(1);
      end else begin
        line_idx <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/glm_update_sequencer.sv
// Minibatch sequencer for the GLM update engine: one op per (sample, partition).
// Optional perf counters are built only when GLM_SEQ_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// ISSUE   | pulse upd_start (or skip straight to FINISH for an empty command)
// WAIT    | op outstanding, upd_regs held until upd_done
// ADVANCE | step partition/sample, decide next op or finish
// FINISH  | one-cycle seq_done, back to IDLE
module glm_update_sequencer
  import glm_seq_pkg::*;
#(
  parameter int PART_LINES = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [CNT_W-1:0]             cmd_num_samples,
  input  logic [15:0]                  cmd_model_offset,
  input  logic [15:0]                  cmd_model_length,
  input  logic [15:0]                  cmd_part_lines,
  input  logic                         cmd_forward_en,
  input  logic                         abort,
  output logic                         upd_start,
  output logic [NUM_REGS-1:0][31:0]    upd_regs,
  input  logic                         upd_done,
  output logic                         seq_done,
  output logic                         seq_aborted,
  output logic                         busy,
  output logic                         err_spurious_done,
  output logic [31:0]                  perf_ops,
  output logic [31:0]                  perf_busy_cycles
);

  t_seqstate         state, state_nxt;
  logic [CNT_W-1:0]  num_samples_q;
  logic [15:0]       offset_q, length_q, part_q;
  logic              forward_q, abort_q, init_done;
  logic              accept, degenerate, iter_advance, regs_live;
  logic [15:0]       line_idx, len;
  logic              last_sample, last_op;

  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE);
  assign cmd_ready  = (state == IDLE) && init_done;
  assign degenerate = (num_samples_q == '0) || (length_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_samples_q <= '0;
      offset_q      <= '0;
      length_q      <= '0;
      part_q        <= '0;
      forward_q     <= 1'b0;
    end else if (accept) begin
      num_samples_q <= cmd_num_samples;
      offset_q      <= cmd_model_offset;
      length_q      <= cmd_model_length;
      part_q        <= (cmd_part_lines == '0) ? 16'(PART_LINES) : cmd_part_lines;
      forward_q     <= cmd_forward_en;
    end
  end

  // cmd_ready stays low until the first cycle after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) init_done <= 1'b0;
    else         init_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      abort_q           <= 1'b0;
      err_spurious_done <= 1'b0;
    end else begin
      if (accept || state == FINISH) abort_q <= 1'b0;
      else if (busy && abort)        abort_q <= 1'b1;
      if (accept)                    err_spurious_done <= 1'b0;
      if (upd_done && state != WAIT) err_spurious_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    upd_start    = 1'b0;
    seq_done     = 1'b0;
    seq_aborted  = 1'b0;
    iter_advance = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (degenerate) begin
          state_nxt = FINISH;
        end else begin
          upd_start = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (upd_done) state_nxt = ADVANCE;
      ADVANCE: begin
        iter_advance = 1'b1;
        state_nxt    = (abort_q || last_op) ? FINISH : ISSUE;
      end
      FINISH: begin
        seq_done    = 1'b1;
        seq_aborted = abort_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // regs are only driven while an op is being presented or is outstanding
  assign regs_live = upd_start || (state == WAIT);

  always_comb begin
    upd_regs = '0;
    if (regs_live) begin
      upd_regs[REG_MODEL_IDX]                   = {len, offset_q + line_idx};
      upd_regs[REG_FLAGS_IDX][FLAG_FORWARD_BIT] = forward_q && last_sample;
    end
  end

  glm_seq_partition_iter #(.CNT_W(CNT_W)) u_iter (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (accept),
    .advance      (iter_advance),
    .num_samples  (num_samples_q),
    .model_length (length_q),
    .part_lines   (part_q),
    .line_idx     (line_idx),
    .len          (len),
    .last_sample  (last_sample),
    .last_op      (last_op)
  );

`ifdef GLM_SEQ_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ops         <= '0;
      perf_busy_cycles <= '0;
    end else if (accept) begin
      perf_ops         <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (upd_start) perf_ops         <= perf_ops + 32'd1;
      if (busy)      perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`else
  assign perf_ops         = '0;
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_glm_update_sequencer.sv
// Scoreboard bench for glm_update_sequencer with a fixed-latency engine model.
module tb_glm_update_sequencer;

  localparam int ENG_LAT = 2;

  typedef struct {
    logic [31:0] r3;
    logic [31:0] r4;
  } op_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_num_samples;
  logic [15:0]       cmd_model_offset;
  logic [15:0]       cmd_model_length;
  logic [15:0]       cmd_part_lines;
  logic              cmd_forward_en;
  logic              abort;
  logic              upd_start;
  logic [4:0][31:0]  upd_regs;
  logic              upd_done;
  logic              seq_done;
  logic              seq_aborted;
  logic              busy;
  logic              err_spurious_done;
  logic [31:0]       perf_ops;
  logic [31:0]       perf_busy_cycles;

  logic              eng_done = 1'b0;
  logic              spur_done = 1'b0;
  logic              eng_off = 1'b0;
  int                n_tests = 0;
  int                n_fail = 0;
  int                n_starts = 0;
  op_t               exp_ops[$];
  bit                exp_done[$];

  assign upd_done = eng_done | spur_done;

  always #5 clk = ~clk;

  glm_update_sequencer dut (
    .clk               (clk),
    .resetn            (resetn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_num_samples   (cmd_num_samples),
    .cmd_model_offset  (cmd_model_offset),
    .cmd_model_length  (cmd_model_length),
    .cmd_part_lines    (cmd_part_lines),
    .cmd_forward_en    (cmd_forward_en),
    .abort             (abort),
    .upd_start         (upd_start),
    .upd_regs          (upd_regs),
    .upd_done          (upd_done),
    .seq_done          (seq_done),
    .seq_aborted       (seq_aborted),
    .busy              (busy),
    .err_spurious_done (err_spurious_done),
    .perf_ops          (perf_ops),
    .perf_busy_cycles  (perf_busy_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic [31:0] r3, input logic fwd);
    op_t o;
    o.r3 = r3;
    o.r4 = {31'd0, fwd};
    exp_ops.push_back(o);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an op or finishes
  initial begin
    op_t e;
    forever begin
      @(negedge clk);
      if (upd_start) begin
        n_starts++;
        if (exp_ops.size() == 0) begin
          check("unexpected_upd_start", 32'd1, 32'd0);
        end else begin
          e = exp_ops.pop_front();
          check("regs3", upd_regs[3], e.r3);
          check("regs4", upd_regs[4], e.r4);
          check("regs0_2", upd_regs[0] | upd_regs[1] | upd_regs[2], 32'd0);
        end
      end
      if (seq_done) begin
        if (exp_done.size() == 0) check("unexpected_seq_done", 32'd1, 32'd0);
        else check("seq_aborted", {31'd0, seq_aborted}, {31'd0, exp_done.pop_front()});
      end
    end
  end

  // Engine model: answers each upd_start after ENG_LAT cycles, checking regs held
  initial begin
    logic [31:0] s3, s4;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (upd_start && !eng_off && resetn) begin
        s3 = upd_regs[3];
        s4 = upd_regs[4];
        repeat (ENG_LAT) @(negedge clk);
        check("regs3_stable", upd_regs[3], s3);
        check("regs4_stable", upd_regs[4], s4);
        if (resetn) eng_done = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [15:0] ns, input logic [15:0] off, input logic [15:0] len,
                          input logic [15:0] part, input logic fwd);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_num_samples  = ns;
    cmd_model_offset = off;
    cmd_model_length = len;
    cmd_part_lines   = part;
    cmd_forward_en   = fwd;
    cmd_valid        = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, busy}, 32'd0);
    check({name, "_ops_drained"}, exp_ops.size(), 32'd0);
    check({name, "_done_drained"}, exp_done.size(), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_num_samples = '0;
    cmd_model_offset = '0;
    cmd_model_length = '0;
    cmd_part_lines = '0;
    cmd_forward_en = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_upd_start", {31'd0, upd_start}, 32'd0);
    check("rst_seq_done", {31'd0, seq_done}, 32'd0);
    check("rst_err", {31'd0, err_spurious_done}, 32'd0);
    check("rst_regs3", upd_regs[3], 32'd0);
    check("rst_perf_ops", perf_ops, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // abort in IDLE must not leak into the next command
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    // single op, default partition
    push_op(32'h0040_0010, 1'b0);
    exp_done.push_back(1'b0);
    send_cmd(16'd1, 16'h0010, 16'd64, 16'd0, 1'b0);
    check("t1_first_start", {31'd0, upd_start}, 32'd1);
    check("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    wait_idle("t1_idle");
`ifdef GLM_SEQ_PERF_EN
    check("t1_perf_ops", perf_ops, 32'd1);
    check("t1_perf_busy", perf_busy_cycles, 32'd5);
`else
    check("t1_perf_ops_off", perf_ops, 32'd0);
    check("t1_perf_busy_off", perf_busy_cycles, 32'd0);
`endif

    // two samples, tail partition shorter
    for (int s = 0; s < 2; s++) begin
      push_op(32'h0028_0000, 1'b0);
      push_op(32'h0028_0028, 1'b0);
      push_op(32'h0014_0050, 1'b0);
    end
    exp_done.push_back(1'b0);
    send_cmd(16'd2, 16'd0, 16'd100, 16'd40, 1'b0);
    wait_idle("t2_idle");
`ifdef GLM_SEQ_PERF_EN
    check("t2_perf_ops", perf_ops, 32'd6);
    check("t2_perf_busy", perf_busy_cycles, 32'd25);
`endif

    // forward flag only on the final sample
    push_op(32'h0010_0200, 1'b0);
    push_op(32'h0010_0200, 1'b0);
    push_op(32'h0010_0200, 1'b1);
    exp_done.push_back(1'b0);
    send_cmd(16'd3, 16'h0200, 16'd16, 16'd0, 1'b1);
    wait_idle("t3_idle");

    // model address wraps mod 2^16
    push_op(32'h0010_FFF0, 1'b0);
    push_op(32'h0010_0000, 1'b0);
    exp_done.push_back(1'b0);
    send_cmd(16'd1, 16'hFFF0, 16'd32, 16'd16, 1'b0);
    wait_idle("t4_idle");

    // abort during 2nd of 4 ops
    begin
      int base;
      int k;
      base = n_starts;
      k = 0;
      push_op(32'h0008_0007, 1'b0);
      push_op(32'h0008_0007, 1'b0);
      exp_done.push_back(1'b1);
      send_cmd(16'd4, 16'h0007, 16'd8, 16'd0, 1'b0);
      while (n_starts < base + 2 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("t5_reached_op2", n_starts, base + 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle("t5_idle");
      check("t5_op_count", n_starts, base + 2);
    end

    // empty command: seq_done two cycles after accept, no op
    exp_done.push_back(1'b0);
    send_cmd(16'd0, 16'h0100, 16'd8, 16'd0, 1'b0);
    check("t6_no_start", {31'd0, upd_start}, 32'd0);
    check("t6_done_not_yet", {31'd0, seq_done}, 32'd0);
    @(negedge clk);
    check("t6_done_at_2", {31'd0, seq_done}, 32'd1);
    wait_idle("t6_idle");

    exp_done.push_back(1'b0);
    send_cmd(16'd3, 16'h0100, 16'd0, 16'd0, 1'b0);
    check("t7_no_start", {31'd0, upd_start}, 32'd0);
    wait_idle("t7_idle");

    // spurious done in IDLE is sticky
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("t8_err_set", {31'd0, err_spurious_done}, 32'd1);
    repeat (3) @(negedge clk);
    check("t8_err_sticky", {31'd0, err_spurious_done}, 32'd1);
    check("t8_busy", {31'd0, busy}, 32'd0);

    // reset while WAIT; accept also clears err
    eng_off = 1'b1;
    push_op(32'h0004_0000, 1'b0);
    send_cmd(16'd1, 16'h0000, 16'd4, 16'd0, 1'b0);
    check("t9_err_cleared", {31'd0, err_spurious_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("t9_busy_wait", {31'd0, busy}, 32'd1);
    check("t9_regs_held", upd_regs[3], 32'h0004_0000);
    resetn = 1'b0;
    #1;
    check("t9_rst_busy", {31'd0, busy}, 32'd0);
    check("t9_rst_regs3", upd_regs[3], 32'd0);
    check("t9_rst_regs4", upd_regs[4], 32'd0);
    check("t9_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("t9_rst_start", {31'd0, upd_start}, 32'd0);
    check("t9_rst_done", {31'd0, seq_done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    eng_off = 1'b0;
    repeat (2) @(negedge clk);
    push_op(32'h0004_0020, 1'b0);
    push_op(32'h0004_0024, 1'b0);
    exp_done.push_back(1'b0);
    send_cmd(16'd1, 16'h0020, 16'd8, 16'd4, 1'b0);
    wait_idle("t10_idle");
    check("t10_err_clear", {31'd0, err_spurious_done}, 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
